// File: rtl/param_pipelined_adder_tree.sv
// param_pipelined_adder_tree
//   Registered binary adder tree. Sums NUM_INPUTS packed operands, one log2 level per
//   clock stage, behind valid/ready handshakes. Accepts one vector per clock.
//
// Parameters
//   DATA_WIDTH  operand width
//   NUM_INPUTS  operand count (>=1)
//   SIGNED      1: two's complement operands (sign-extend), 0: unsigned (zero-extend)
//   OUT_WIDTH   result width (defaults to the full, non-overflowing width)
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_data    operand i at [i*DATA_WIDTH +: DATA_WIDTH]
//   in_valid   in_data valid this cycle
//   in_ready   block accepts in_data this cycle (combinational, equals the advance enable)
//   out_data   registered sum
//   out_valid  out_data valid
//   out_ready  downstream accepts out_data
//
// Build option
//   ADDER_TREE_SAT_EN  when defined and OUT_WIDTH is narrower than the full sum, the result
//                      clamps to the OUT_WIDTH range; otherwise the low bits are kept (wrap).

module param_pipelined_adder_tree #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_INPUTS = 9,
    parameter int unsigned SIGNED     = 1,
    parameter int unsigned OUT_WIDTH  = DATA_WIDTH + $clog2(NUM_INPUTS)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_INPUTS*DATA_WIDTH-1:0] in_data,
    input  logic                             in_valid,
    output logic                             in_ready,
    output logic [OUT_WIDTH-1:0]             out_data,
    output logic                             out_valid,
    input  logic                             out_ready
);

    localparam int unsigned FULL_W = DATA_WIDTH + $clog2(NUM_INPUTS);
    localparam int unsigned LAT    = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;

    // Number of terms present at a given tree level (level 0 = extended operands).
    function automatic int unsigned level_cnt(input int unsigned lvl);
        int unsigned c;
        c = NUM_INPUTS;
        for (int unsigned i = 0; i < lvl; i++) begin
            c = (c + 1) / 2;
        end
        return c;
    endfunction

    // Whole pipeline advances together; a full output register blocks everything upstream.
    logic adv;
    assign adv      = out_ready | ~out_valid;
    assign in_ready = adv;

    // Tree levels: 0 is combinational extension, 1..LAT-1 are registers, LAT is the
    // combinational final sum that feeds the output register.
    for (genvar k = 0; k <= LAT; k++) begin : g_lvl
        localparam int unsigned CNT = level_cnt(k);
        logic [FULL_W-1:0] node [CNT];

        if (k == 0) begin : g_ext
            for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_op
                if (SIGNED != 0) begin : g_s
                    assign node[i] = FULL_W'(signed'(in_data[i*DATA_WIDTH +: DATA_WIDTH]));
                end else begin : g_u
                    assign node[i] = FULL_W'(in_data[i*DATA_WIDTH +: DATA_WIDTH]);
                end
            end
        end else begin : g_add
            localparam int unsigned PREV = level_cnt(k - 1);
            logic [FULL_W-1:0] sum_c [CNT];

            // Pairwise adds; an odd leftover term passes straight through.
            for (genvar j = 0; j < CNT; j++) begin : g_pair
                if (2 * j + 1 < PREV) begin : g_two
                    assign sum_c[j] = g_lvl[k-1].node[2*j] + g_lvl[k-1].node[2*j+1];
                end else begin : g_one
                    assign sum_c[j] = g_lvl[k-1].node[2*j];
                end
            end

            if (k < LAT) begin : g_reg
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        for (int unsigned n = 0; n < CNT; n++) node[n] <= '0;
                    end else if (adv) begin
                        for (int unsigned n = 0; n < CNT; n++) node[n] <= sum_c[n];
                    end
                end
            end else begin : g_last
                assign node[0] = sum_c[0];
            end
        end
    end

    logic [FULL_W-1:0]    full_c;
    logic [OUT_WIDTH-1:0] narrow_c;
    assign full_c = g_lvl[LAT].node[0];

    // Fit the full-width sum into OUT_WIDTH.
    if (OUT_WIDTH >= FULL_W) begin : g_widen
        if (SIGNED != 0) begin : g_s
            assign narrow_c = OUT_WIDTH'(signed'(full_c));
        end else begin : g_u
            assign narrow_c = OUT_WIDTH'(full_c);
        end
    end else begin : g_narrow
`ifdef ADDER_TREE_SAT_EN
        localparam logic [OUT_WIDTH-1:0] S_MIN = OUT_WIDTH'(1) << (OUT_WIDTH - 1);
        localparam logic [OUT_WIDTH-1:0] S_MAX = ~S_MIN;
        if (SIGNED != 0) begin : g_sat_s
            // In range only when every bit from the narrow sign bit upward agrees.
            always_comb begin
                narrow_c = full_c[OUT_WIDTH-1:0];
                if (full_c[FULL_W-1:OUT_WIDTH-1] != {(FULL_W-OUT_WIDTH+1){full_c[FULL_W-1]}}) begin
                    narrow_c = full_c[FULL_W-1] ? S_MIN : S_MAX;
                end
            end
        end else begin : g_sat_u
            always_comb begin
                narrow_c = full_c[OUT_WIDTH-1:0];
                if (|full_c[FULL_W-1:OUT_WIDTH]) begin
                    narrow_c = '1;
                end
            end
        end
`else
        logic unused_hi;
        assign unused_hi = ^full_c[FULL_W-1:OUT_WIDTH];
        assign narrow_c  = full_c[OUT_WIDTH-1:0];
`endif
    end

    // Valid bits shift alongside the data; last one is the output valid.
    logic [LAT-1:0] vld;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld      <= '0;
            out_data <= '0;
        end else if (adv) begin
            vld[0] <= in_valid;
            for (int unsigned k = 1; k < LAT; k++) vld[k] <= vld[k-1];
            out_data <= narrow_c;
        end
    end

    assign out_valid = vld[LAT-1];

endmodule

// File: tb/tb_param_pipelined_adder_tree.sv
// tb_param_pipelined_adder_tree
//   Directed bench for param_pipelined_adder_tree. Four instances share clock, reset and
//   handshake inputs: 9x32 signed, 9x32 unsigned, 9x8 signed narrowed to 8 bits, and a
//   single 8-bit signed operand widened to 12 bits.

module tb_param_pipelined_adder_tree;

    localparam int unsigned N = 9;

`ifdef ADDER_TREE_SAT_EN
    localparam logic [7:0] N_EXP_A = 8'h7F;   // 900 clamps to 127
    localparam logic [7:0] N_EXP_C = 8'h80;   // -900 clamps to -128
`else
    localparam logic [7:0] N_EXP_A = 8'h84;   // 900 mod 256
    localparam logic [7:0] N_EXP_C = 8'h7C;   // -900 mod 256
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0;
    logic out_ready = 1'b1;

    logic [N*32-1:0] s_in = '0;
    logic [N*32-1:0] u_in = '0;
    logic [N*8-1:0]  n_in = '0;
    logic [7:0]      o_in = '0;

    logic [35:0] s_out, u_out;
    logic [7:0]  n_out;
    logic [11:0] o_out;
    logic s_ready, u_ready, n_ready, o_ready;
    logic s_valid, u_valid, n_valid, o_valid;

    int checks = 0;
    int failures = 0;
    int sent;
    int recv;

    always #5 clk = ~clk;

    param_pipelined_adder_tree #(.DATA_WIDTH(32), .NUM_INPUTS(9), .SIGNED(1)) u_s (
        .clk(clk), .rst_n(rst_n), .in_data(s_in), .in_valid(in_valid), .in_ready(s_ready),
        .out_data(s_out), .out_valid(s_valid), .out_ready(out_ready));

    param_pipelined_adder_tree #(.DATA_WIDTH(32), .NUM_INPUTS(9), .SIGNED(0)) u_u (
        .clk(clk), .rst_n(rst_n), .in_data(u_in), .in_valid(in_valid), .in_ready(u_ready),
        .out_data(u_out), .out_valid(u_valid), .out_ready(out_ready));

    param_pipelined_adder_tree #(.DATA_WIDTH(8), .NUM_INPUTS(9), .SIGNED(1), .OUT_WIDTH(8)) u_n (
        .clk(clk), .rst_n(rst_n), .in_data(n_in), .in_valid(in_valid), .in_ready(n_ready),
        .out_data(n_out), .out_valid(n_valid), .out_ready(out_ready));

    param_pipelined_adder_tree #(.DATA_WIDTH(8), .NUM_INPUTS(1), .SIGNED(1), .OUT_WIDTH(12)) u_o (
        .clk(clk), .rst_n(rst_n), .in_data(o_in), .in_valid(in_valid), .in_ready(o_ready),
        .out_data(o_out), .out_valid(o_valid), .out_ready(out_ready));

    // Operand k = base + stp*k.
    function automatic logic [N*32-1:0] vec32(input logic [31:0] base, input logic [31:0] stp);
        logic [N*32-1:0] v;
        for (int k = 0; k < N; k++) v[k*32 +: 32] = base + stp * 32'(k);
        return v;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset held with in_valid high: nothing may be captured.
        s_in = vec32(32'd1, 32'd1);
        u_in = '1;
        n_in = {N{8'd100}};
        o_in = 8'h80;
        in_valid = 1'b1;
        rst_n = 1'b0;
        step();
        step();
        check("rst_s_valid", 64'(s_valid), 64'd0);
        check("rst_s_data", 64'(s_out), 64'd0);
        check("rst_n_valid", 64'(n_valid), 64'd0);
        check("rst_n_data", 64'(n_out), 64'd0);
        check("rst_o_valid", 64'(o_valid), 64'd0);
        check("rst_o_data", 64'(o_out), 64'd0);

        in_valid = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("idle_valids", 64'({s_valid, u_valid, n_valid, o_valid}), 64'd0);
        end

        // Three back-to-back vectors A, B, C.
        in_valid = 1'b1;
        #1;
        check("ready_idle", 64'(s_ready), 64'd1);
        step();
        check("a_o_valid", 64'(o_valid), 64'd1);
        check("a_o_data", 64'(o_out), 64'hF80);
        check("a_s_early", 64'(s_valid), 64'd0);

        s_in = '1;
        u_in = vec32(32'd1, 32'd1);
        n_in = {N{8'hFF}};
        o_in = 8'h7F;
        step();
        check("b_o_data", 64'(o_out), 64'h07F);
        check("b_s_early", 64'(s_valid), 64'd0);

        s_in = vec32(32'd10, 32'd10);
        u_in = '0;
        n_in = {N{8'h9C}};
        o_in = 8'h01;
        step();
        check("c_o_data", 64'(o_out), 64'h001);
        check("c_s_early", 64'(s_valid), 64'd0);

        in_valid = 1'b0;
        step();
        check("a_s_valid", 64'(s_valid), 64'd1);
        check("a_s_data", 64'(s_out), 64'd45);
        check("a_u_data", 64'(u_out), 64'h8_FFFF_FFF7);
        check("a_n_data", 64'(n_out), 64'(N_EXP_A));
        check("o_bubble", 64'(o_valid), 64'd0);
        step();
        check("b_s_data", 64'(s_out), 64'h F_FFFF_FFF7);
        check("b_u_data", 64'(u_out), 64'd45);
        check("b_n_data", 64'(n_out), 64'hF7);
        step();
        check("c_s_data", 64'(s_out), 64'd450);
        check("c_u_data", 64'(u_out), 64'd0);
        check("c_n_data", 64'(n_out), 64'(N_EXP_C));
        step();
        check("drained", 64'(s_valid), 64'd0);

        // Ten-vector stream with a three-cycle output stall mid-stream.
        sent = 0;
        recv = 0;
        for (int cyc = 0; cyc < 60 && recv < 10; cyc++) begin
            out_ready = !(cyc >= 6 && cyc <= 8);
            in_valid = (sent < 10);
            s_in = vec32(32'(sent), 32'd1);
            #1;
            if (s_valid && !out_ready) check("bp_in_ready", 64'(s_ready), 64'd0);
            if (s_valid && out_ready) begin
                check("bp_data", 64'(s_out), 64'(9 * recv + 36));
                recv++;
            end
            if (in_valid && s_ready) sent++;
            step();
        end
        check("bp_count", 64'(recv), 64'd10);
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        step();

        // Reset with one result at the output and three more in flight.
        in_valid = 1'b1;
        s_in = vec32(32'd100, 32'd0);
        for (int i = 0; i < 4; i++) step();
        check("pre_rst_valid", 64'(s_valid), 64'd1);
        check("pre_rst_data", 64'(s_out), 64'd900);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 64'(s_valid), 64'd0);
        check("mid_rst_data", 64'(s_out), 64'd0);
        step();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            check("post_rst_valid", 64'(s_valid), 64'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
